// File: rtl/rotor_stepper.sv
// rotor_stepper: upstream stage of the rotor chain.
// Accepts one-hot letters, applies Enigma odometer stepping (with the middle-rotor
// double-step) before encipherment, and presents each letter with its post-step
// rotor positions through a one-entry output register. Also loads keys and flags
// letters that are not exactly one-hot.
module rotor_stepper #(
    parameter int NOTCH_FAST = 16,
    parameter int NOTCH_MID  = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [4:0]       load_pos_fast,
    input  logic [4:0]       load_pos_mid,
    input  logic [4:0]       load_pos_slow,
    input  logic             in_valid,
    input  logic [25:0]      in_char,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      out_char,
    output logic [4:0]       out_pos_fast,
    output logic [4:0]       out_pos_mid,
    output logic [4:0]       out_pos_slow,
    output logic             out_err,
    output logic [CNT_W-1:0] char_count
);

    localparam logic [4:0] NOTCH_F = NOTCH_FAST[4:0];
    localparam logic [4:0] NOTCH_M = NOTCH_MID[4:0];

    // Fold a 5-bit key value into 0..25 (26..31 map to 0..5).
    function automatic logic [4:0] mod26(input logic [4:0] v);
        return (v >= 5'd26) ? (v - 5'd26) : v;
    endfunction

    // Advance one rotor position, 25 wraps to 0.
    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : (v + 5'd1);
    endfunction

    logic [4:0] pos_fast;
    logic [4:0] pos_mid;
    logic [4:0] pos_slow;
    logic [4:0] step_fast;
    logic [4:0] step_mid_pos;
    logic [4:0] step_slow_pos;
    logic       accept;
    logic       one_hot;

    assign in_ready = !load_valid && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign one_hot  = (in_char != 26'd0) && ((in_char & (in_char - 26'd1)) == 26'd0);

    // Odometer stepping: middle steps on fast notch or on its own notch (double-step).
    always_comb begin
        step_fast     = inc26(pos_fast);
        step_mid_pos  = pos_mid;
        step_slow_pos = pos_slow;
        if ((pos_fast == NOTCH_F) || (pos_mid == NOTCH_M)) begin
            step_mid_pos = inc26(pos_mid);
        end
        if (pos_mid == NOTCH_M) begin
            step_slow_pos = inc26(pos_slow);
        end
    end

    // Rotor position state: key load has priority, malformed letters do not step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_fast <= 5'd0;
            pos_mid  <= 5'd0;
            pos_slow <= 5'd0;
        end else if (load_valid) begin
            pos_fast <= mod26(load_pos_fast);
            pos_mid  <= mod26(load_pos_mid);
            pos_slow <= mod26(load_pos_slow);
        end else if (accept && one_hot) begin
            pos_fast <= step_fast;
            pos_mid  <= step_mid_pos;
            pos_slow <= step_slow_pos;
        end
    end

    // One-entry output register: refills on accept, drains on out_ready, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_char     <= 26'd0;
            out_pos_fast <= 5'd0;
            out_pos_mid  <= 5'd0;
            out_pos_slow <= 5'd0;
            out_err      <= 1'b0;
            char_count   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_char  <= in_char;
            out_err   <= !one_hot;
            if (one_hot) begin
                out_pos_fast <= step_fast;
                out_pos_mid  <= step_mid_pos;
                out_pos_slow <= step_slow_pos;
                char_count   <= char_count + 1'b1;
            end else begin
                out_pos_fast <= pos_fast;
                out_pos_mid  <= pos_mid;
                out_pos_slow <= pos_slow;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotor_stepper.sv
// tb_rotor_stepper: directed bench for rotor_stepper with hand-computed expectations.
module tb_rotor_stepper;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [4:0]  load_pos_fast;
    logic [4:0]  load_pos_mid;
    logic [4:0]  load_pos_slow;
    logic        in_valid;
    logic [25:0] in_char;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_char;
    logic [4:0]  out_pos_fast;
    logic [4:0]  out_pos_mid;
    logic [4:0]  out_pos_slow;
    logic        out_err;
    logic [15:0] char_count;

    int errors = 0;
    int checks = 0;

    rotor_stepper #(.NOTCH_FAST(16), .NOTCH_MID(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_pos_fast(load_pos_fast),
        .load_pos_mid (load_pos_mid),
        .load_pos_slow(load_pos_slow),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_char     (out_char),
        .out_pos_fast (out_pos_fast),
        .out_pos_mid  (out_pos_mid),
        .out_pos_slow (out_pos_slow),
        .out_err      (out_err),
        .char_count   (char_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; in_valid = 1'b0; in_char = 26'd0; out_ready = 1'b1;
        load_pos_fast = 5'd0; load_pos_mid = 5'd0; load_pos_slow = 5'd0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_char !== 26'd0 || char_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b err=%b char=%h count=%0d, want 0/0/0/0", out_valid, out_err, out_char, char_count);
        end
        checks++;
        if ({out_pos_fast, out_pos_mid, out_pos_slow} !== 15'd0) begin
            errors++;
            $display("FAIL reset_pos: got %0d/%0d/%0d want 0/0/0", out_pos_fast, out_pos_mid, out_pos_slow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_double_step();
        load_valid = 1'b1; load_pos_fast = 5'd16; load_pos_mid = 5'd3; load_pos_slow = 5'd0;
        tick();
        load_valid = 1'b0;
        in_valid = 1'b1; in_char = 26'd1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_char !== 26'd1 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd17, 5'd4, 5'd0}) begin
            errors++;
            $display("FAIL step_A: valid=%b char=%h pos=%0d/%0d/%0d want 1/1/17/4/0", out_valid, out_char, out_pos_fast, out_pos_mid, out_pos_slow);
        end
        in_char = 26'd2;
        tick();
        checks++;
        if (out_char !== 26'd2 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd18, 5'd5, 5'd1}) begin
            errors++;
            $display("FAIL step_B_double: char=%h pos=%0d/%0d/%0d want 2/18/5/1", out_char, out_pos_fast, out_pos_mid, out_pos_slow);
        end
        in_char = 26'd4;
        tick();
        checks++;
        if (out_char !== 26'd4 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd19, 5'd5, 5'd1} || char_count !== 16'd3) begin
            errors++;
            $display("FAIL step_C: char=%h pos=%0d/%0d/%0d count=%0d want 4/19/5/1/3", out_char, out_pos_fast, out_pos_mid, out_pos_slow, char_count);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_char !== 26'd4) begin
            errors++;
            $display("FAIL drain: valid=%b char=%h want 0/4", out_valid, out_char);
        end
    endtask

    task automatic test_wrap();
        load_valid = 1'b1; load_pos_fast = 5'd25; load_pos_mid = 5'd25; load_pos_slow = 5'd25;
        tick();
        load_valid = 1'b0;
        in_valid = 1'b1; in_char = 26'd8;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd0, 5'd25, 5'd25} || char_count !== 16'd4) begin
            errors++;
            $display("FAIL wrap: pos=%0d/%0d/%0d count=%0d want 0/25/25/4", out_pos_fast, out_pos_mid, out_pos_slow, char_count);
        end
        tick();
    endtask

    task automatic test_load_priority();
        load_valid = 1'b1; load_pos_fast = 5'd30; load_pos_mid = 5'd31; load_pos_slow = 5'd26;
        in_valid = 1'b1; in_char = 26'd16;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_blocks_ready: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_no_accept: out_valid=%b want 0", out_valid);
        end
        load_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_load: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_char !== 26'd16 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd5, 5'd5, 5'd0}) begin
            errors++;
            $display("FAIL load_mod26: valid=%b char=%h pos=%0d/%0d/%0d want 1/10/5/5/0", out_valid, out_char, out_pos_fast, out_pos_mid, out_pos_slow);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_char = 26'd8;
        tick();
        in_char = 26'd16;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_char !== 26'd8 ||
                {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd6, 5'd5, 5'd0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rdy=%b vld=%b char=%h pos=%0d/%0d/%0d want 0/1/8/6/5/0", i, in_ready, out_valid, out_char, out_pos_fast, out_pos_mid, out_pos_slow);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_on_drain: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_char !== 26'd16 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd7, 5'd5, 5'd0} || char_count !== 16'd7) begin
            errors++;
            $display("FAIL second_letter: vld=%b char=%h pos=%0d/%0d/%0d count=%0d want 1/10/7/5/0/7", out_valid, out_char, out_pos_fast, out_pos_mid, out_pos_slow, char_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_duplicate: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_malformed();
        in_valid = 1'b1; in_char = 26'd3;
        tick();
        checks++;
        if (out_err !== 1'b1 || out_char !== 26'd3 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd7, 5'd5, 5'd0} || char_count !== 16'd7) begin
            errors++;
            $display("FAIL bad_two_hot: err=%b char=%h pos=%0d/%0d/%0d count=%0d want 1/3/7/5/0/7", out_err, out_char, out_pos_fast, out_pos_mid, out_pos_slow, char_count);
        end
        in_char = 26'd0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_char !== 26'd0 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd7, 5'd5, 5'd0} || char_count !== 16'd7) begin
            errors++;
            $display("FAIL bad_zero: vld=%b err=%b char=%h pos=%0d/%0d/%0d count=%0d want 1/1/0/7/5/0/7", out_valid, out_err, out_char, out_pos_fast, out_pos_mid, out_pos_slow, char_count);
        end
        in_char = 26'd32;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_err !== 1'b0 || {out_pos_fast, out_pos_mid, out_pos_slow} !== {5'd8, 5'd5, 5'd0} || char_count !== 16'd8) begin
            errors++;
            $display("FAIL good_after_bad: err=%b pos=%0d/%0d/%0d count=%0d want 0/8/5/0/8", out_err, out_pos_fast, out_pos_mid, out_pos_slow, char_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [25:0] exp_char;
        logic [4:0]  exp_fast;
        logic [15:0] exp_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (out_valid !== 1'b0 || {out_pos_fast, out_pos_mid, out_pos_slow} !== 15'd0 || char_count !== 16'd0) begin
                    errors++;
                    $display("FAIL async_reset: vld=%b pos=%0d/%0d/%0d count=%0d want 0/0/0/0/0", out_valid, out_pos_fast, out_pos_mid, out_pos_slow, char_count);
                end
                rst_n = 1'b1;
            end
            in_char = 26'd1 << i;
            tick();
            exp_char = 26'd1 << i;
            exp_fast = (i < 5) ? 5'(9 + i) : 5'(i - 4);
            exp_cnt  = (i < 5) ? 16'(9 + i) : 16'(i - 4);
            checks++;
            if (out_valid !== 1'b1 || out_char !== exp_char || out_pos_fast !== exp_fast ||
                out_pos_mid !== ((i < 5) ? 5'd5 : 5'd0) || out_pos_slow !== 5'd0 || char_count !== exp_cnt) begin
                errors++;
                $display("FAIL b2b[%0d]: vld=%b char=%h pos=%0d/%0d/%0d count=%0d want 1/%h/%0d/%0d/0/%0d", i, out_valid, out_char, out_pos_fast, out_pos_mid, out_pos_slow, char_count, exp_char, exp_fast, (i < 5) ? 5 : 0, exp_cnt);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_double_step();
        test_wrap();
        test_load_priority();
        test_backpressure();
        test_malformed();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotor_stepper.md
Name: rotor_stepper

Overview:
- Upstream stage of the rotor chain: accepts one-hot letters (26-bit vector, bit 0 = A) on a valid/ready handshake.
- Advances the three rotor positions with Enigma odometer stepping, including the middle-rotor double-step. Stepping happens before encipherment.
- Presents each letter with its post-step positions to the downstream rotor instances (0..25 position inputs) through a one-entry output register.
- Also handles key loading and flags malformed letters.

Parameters:
- NOTCH_FAST, 16, fast-rotor position (Q) at which the next keypress carries into the middle rotor
- NOTCH_MID, 4, middle-rotor position (E) at which the next keypress carries into the slow rotor and double-steps the middle rotor
- CNT_W, 16, width of the processed-character counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  load initial key positions this cycle
- load_pos_fast  in  5  initial fast position
- load_pos_mid  in  5  initial middle position
- load_pos_slow  in  5  initial slow position
- in_valid  in  1  letter offered
- in_char  in  26  one-hot letter
- in_ready  out  1  letter accepted when in_valid and in_ready are both high
- out_valid  out  1  output register holds a letter
- out_ready  in  1  downstream consumes when out_valid and out_ready are both high
- out_char  out  26  registered letter
- out_pos_fast  out  5  post-step fast position for this letter
- out_pos_mid  out  5  post-step middle position
- out_pos_slow  out  5  post-step slow position
- out_err  out  1  letter was not exactly one-hot
- char_count  out  CNT_W  count of accepted valid letters, wraps at 2^CNT_W

Behaviour:
- Reset (async assert, sync release):
  - internal positions = 0
  - out_valid = 0, out_char = 0, out_pos_* = 0, out_err = 0, char_count = 0
- Key load:
  - Reduce each load_pos_* mod 26: values 26..31 become 0..5.
  - load_valid takes priority: in_ready = 0 in any cycle with load_valid = 1.
  - New positions take effect next cycle.
  - Load does not alter an output entry already in the register.
- in_ready = !load_valid && (!out_valid || out_ready). The output register can refill in the same cycle it drains, giving full throughput.
- On acceptance, with current positions F, M, S:
  - step_mid = (F == NOTCH_FAST) || (M == NOTCH_MID)
  - step_slow = (M == NOTCH_MID)
  - F' = (F+1) mod 26; M' = step_mid ? (M+1) mod 26 : M; S' = step_slow ? (S+1) mod 26 : S
  - 25 wraps to 0 on every rotor. No carry out of the slow rotor.
  - Next cycle: positions = F'/M'/S', out_char = in_char, out_pos_* = F'/M'/S', out_valid = 1, out_err = 0, char_count + 1.
- Malformed letter (popcount of in_char is not 1, including all-zero):
  - Accepted normally; out_char = in_char, out_err = 1.
  - Positions do not step; out_pos_* = current positions.
  - char_count does not increment.
- Latency is 1 cycle from acceptance to out_valid.
- out_* is held stable while out_valid && !out_ready.
- When out_valid && out_ready && no acceptance: out_valid falls to 0 and data holds its last value.
- Reset mid-operation: an in-flight letter is dropped; outputs return to reset values immediately.

Test Plan:
- Reset, then load F/M/S = 16/3/0 and send A (bit 0) -> out_pos 17/4/0; send B -> 18/5/1 (double step); send C -> 19/5/1.
- Load 25/25/25 and send one letter -> out_pos 0/25/25 (wrap, no carry because 25 is not a notch).
- Load 30/31/26 -> positions 4/5/0. Assert load_valid together with in_valid on the same cycle -> in_ready = 0 that cycle and the letter is accepted only after load deasserts.
- Hold out_ready = 0 with two letters queued -> in_ready = 0, out_char and out_pos stay stable for 5 cycles. Raise out_ready -> second letter appears on the next cycle, no loss or duplication.
- Send in_char = 0x0000003 and then 0 -> out_err = 1 both times, positions unchanged, char_count unchanged. Then send a valid letter -> out_err = 0, step occurs, count + 1.
- Send 10 letters with out_ready always high -> back-to-back out_valid. Assert rst_n low on letter 6 -> out_valid = 0 and positions = 0 immediately, char_count = 0.
